memory_stage: RTL

- Y86-64 pipeline memory stage: consumer side of the execute outputs.
- Latches the execute results (`e_*`) into the E/M pipeline register (`M_*`) with stall/bubble control.
- Owns the byte-addressed data memory: performs 8-byte little-endian reads and writes, and produces `m_valM`/`m_stat` for writeback and forwarding.
- Tracks a sticky fault state that inhibits memory writes after the first non-AOK instruction.

---
 rtl/memory_stage.sv | 133 +++++++++++++
 1 files changed

// File: rtl/memory_stage.sv
// Y86-64 memory stage: E/M pipeline register, byte-addressed data memory and sticky fault flag.
// Optional out-of-range address faulting is enabled by defining MEM_BOUNDS_CHECK_EN.
module memory_stage #(
  parameter int MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        M_stall,
  input  logic        M_bubble,
  input  logic [1:0]  e_stat,
  input  logic [3:0]  e_icode,
  input  logic [3:0]  e_ifun,
  input  logic        e_Cnd,
  input  logic [63:0] e_valE,
  input  logic [63:0] e_valA,
  input  logic [3:0]  e_dstE,
  input  logic [3:0]  e_dstM,
  output logic [1:0]  M_stat,
  output logic [3:0]  M_icode,
  output logic [3:0]  M_ifun,
  output logic        M_Cnd,
  output logic [63:0] M_valE,
  output logic [63:0] M_valA,
  output logic [3:0]  M_dstE,
  output logic [3:0]  M_dstM,
  output logic [63:0] m_valM,
  output logic [1:0]  m_stat,
  output logic        mem_halted
);
  localparam int          AW     = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
  localparam logic [63:0] MEM_SZ = 64'(MEM_BYTES);
  localparam logic [1:0]  ST_AOK = 2'b00;
  localparam logic [1:0]  ST_ADR = 2'b10;

  typedef struct packed {
    logic [1:0]  stat;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic        cnd;
    logic [63:0] val_e;
    logic [63:0] val_a;
    logic [3:0]  dst_e;
    logic [3:0]  dst_m;
  } mreg_t;

  localparam mreg_t NOP = '{stat: 2'b00, icode: 4'h0, ifun: 4'h0, cnd: 1'b0,
                            val_e: 64'd0, val_a: 64'd0, dst_e: 4'hF, dst_m: 4'hF};

  mreg_t       mreg_q, mreg_d;
  logic        halted_q, halted_d;
  logic [7:0]  mem [MEM_BYTES];
  logic [63:0] addr;
  logic        rd_en, wr_en, fault, mem_we;
  logic [AW-1:0] idx [8];
  logic [63:0] rd_raw;

  always_comb begin
    mreg_d = mreg_q;
    if (M_bubble)     mreg_d = NOP;
    else if (!M_stall) mreg_d = '{stat: e_stat, icode: e_icode, ifun: e_ifun, cnd: e_Cnd,
                                  val_e: e_valE, val_a: e_valA, dst_e: e_dstE, dst_m: e_dstM};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mreg_q   <= NOP;
      halted_q <= 1'b0;
    end else begin
      mreg_q   <= mreg_d;
      halted_q <= halted_d;
    end
  end

  // ret/popq address the old stack pointer (valA); everything else uses valE
  always_comb begin
    rd_en = 1'b0;
    wr_en = 1'b0;
    addr  = mreg_q.val_e;
    case (mreg_q.icode)
      4'h4, 4'h8, 4'hA: wr_en = 1'b1;
      4'h5:             rd_en = 1'b1;
      4'h9, 4'hB: begin
        rd_en = 1'b1;
        addr  = mreg_q.val_a;
      end
      default: ;
    endcase
  end

`ifdef MEM_BOUNDS_CHECK_EN
  assign fault = (rd_en || wr_en) && (({1'b0, addr} + 65'd7) >= {1'b0, MEM_SZ});
`else
  assign fault = 1'b0;
`endif

  // Byte indices wrap modulo the memory size; with bounds checking on, any
  // non-faulting access is already in range so the wrap is a no-op.
  always_comb begin
    logic [63:0] base, sum;
    base = addr % MEM_SZ;
    sum  = 64'd0;
    for (int k = 0; k < 8; k++) begin
      sum = base + 64'(k);
      if (sum >= MEM_SZ) sum = sum - MEM_SZ;
      idx[k] = sum[AW-1:0];
    end
  end

  always_comb begin
    rd_raw = 64'd0;
    for (int k = 0; k < 8; k++) rd_raw[8*k +: 8] = mem[idx[k]];
  end

  assign m_valM   = (rd_en && !fault) ? rd_raw : 64'd0;
  assign m_stat   = (mreg_q.stat == ST_AOK && fault) ? ST_ADR : mreg_q.stat;
  assign halted_d = halted_q || (m_stat != ST_AOK);
  assign mem_we   = wr_en && (mreg_q.stat == ST_AOK) && !fault && !halted_q && !rst;

  always_ff @(posedge clk) begin
    if (mem_we)
      for (int k = 0; k < 8; k++) mem[idx[k]] <= mreg_q.val_a[8*k +: 8];
  end

  assign M_stat     = mreg_q.stat;
  assign M_icode    = mreg_q.icode;
  assign M_ifun     = mreg_q.ifun;
  assign M_Cnd      = mreg_q.cnd;
  assign M_valE     = mreg_q.val_e;
  assign M_valA     = mreg_q.val_a;
  assign M_dstE     = mreg_q.dst_e;
  assign M_dstM     = mreg_q.dst_m;
  assign mem_halted = halted_q;
endmodule
